enemy_control: RTL



---
 rtl/enemy_control.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/enemy_control.sv
`default_nettype none
// ============================================================================
// Module   : enemy_control
// Brief    : Frame-paced spawn/draw/update sequencer for the enemy datapath.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_control #(
    parameter int unsigned FRAME_DIV       = 833333,
    parameter int unsigned SPEED_INIT      = 1,
    parameter int unsigned SPEED_MAX       = 7,
    parameter int unsigned LIVES_INIT      = 3,
    parameter int unsigned KILLS_PER_LEVEL = 8,
    parameter int unsigned X_MAX           = 151
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hit,
    input  logic       bottomReached,
    input  logic       drawDone,
    output logic       inResetState,
    output logic       inUpdatePositionState,
    output logic [7:0] enemyXIn,
    output logic [2:0] speed,
    output logic       drawReq,
    output logic [1:0] lives,
    output logic [7:0] kills,
    output logic       gameOver
);

    localparam int unsigned c_FRAME_W = $clog2(FRAME_DIV);

    localparam logic [c_FRAME_W-1:0] c_FRAME_LAST = c_FRAME_W'(FRAME_DIV - 1);
    localparam logic [2:0]           c_SPEED_INIT = 3'(SPEED_INIT);
    localparam logic [2:0]           c_SPEED_MAX  = 3'(SPEED_MAX);
    localparam logic [1:0]           c_LIVES_INIT = 2'(LIVES_INIT);
    localparam logic [7:0]           c_X_MAX      = 8'(X_MAX);
    localparam logic [7:0]           c_X_WRAP     = 8'(X_MAX + 1);
    localparam logic [7:0]           c_LFSR_SEED  = 8'hA5;
    // Right-shift Galois mask for x^8+x^6+x^5+x^4+1
    localparam logic [7:0]           c_LFSR_TAPS  = 8'hB8;

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_SPAWN      = 3'd1;
    localparam logic [2:0] c_DRAW       = 3'd2;
    localparam logic [2:0] c_WAIT_FRAME = 3'd3;
    localparam logic [2:0] c_UPDATE     = 3'd4;
    localparam logic [2:0] c_CHECK      = 3'd5;
    localparam logic [2:0] c_GAME_OVER  = 3'd6;

    logic [2:0]           r_state;
    logic [2:0]           w_stateNext;
    logic [c_FRAME_W-1:0] r_frameCnt;
    logic                 r_hitPending;
    logic [7:0]           r_lfsr;
    logic [7:0]           r_enemyX;
    logic [7:0]           r_kills;
    logic [2:0]           r_speed;
    logic [1:0]           r_lives;

    logic                 w_hitNow;
    logic                 w_enterSpawn;
    logic                 w_enterWait;
    logic                 w_restart;
    logic                 w_levelUp;
    logic [7:0]           w_killsInc;
    logic [1:0]           w_livesDec;
    logic [7:0]           w_spawnX;
    logic [7:0]           w_lfsrNext;

    // A hit landing in CHECK itself must count for that CHECK
    assign w_hitNow     = r_hitPending | hit;
    assign w_killsInc   = r_kills + 8'd1;
    assign w_livesDec   = r_lives - 2'd1;
    assign w_levelUp    = ((32'(w_killsInc) % KILLS_PER_LEVEL) == 32'd0);
    assign w_enterSpawn = (w_stateNext == c_SPAWN);
    assign w_enterWait  = (r_state == c_DRAW) && drawDone;
    assign w_restart    = (r_state == c_GAME_OVER) && start;
    assign w_spawnX     = (r_lfsr <= c_X_MAX) ? r_lfsr : (r_lfsr - c_X_WRAP);
    assign w_lfsrNext   = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? c_LFSR_TAPS : 8'h00);

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_stateNext = c_SPAWN;
                end
            end
            c_SPAWN: begin
                w_stateNext = c_DRAW;
            end
            c_DRAW: begin
                if (drawDone) begin
                    w_stateNext = c_WAIT_FRAME;
                end
            end
            c_WAIT_FRAME: begin
                if (r_frameCnt == c_FRAME_LAST) begin
                    w_stateNext = c_UPDATE;
                end
            end
            c_UPDATE: begin
                w_stateNext = c_CHECK;
            end
            c_CHECK: begin
                if (w_hitNow) begin
                    w_stateNext = c_SPAWN;
                end else if (bottomReached) begin
                    w_stateNext = (w_livesDec == 2'd0) ? c_GAME_OVER : c_SPAWN;
                end else begin
                    w_stateNext = c_DRAW;
                end
            end
            c_GAME_OVER: begin
                if (start) begin
                    w_stateNext = c_SPAWN;
                end
            end
            default: begin
                w_stateNext = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frameCnt <= '0;
        end else if (w_enterWait) begin
            r_frameCnt <= '0;
        end else if (r_state == c_WAIT_FRAME) begin
            r_frameCnt <= r_frameCnt + c_FRAME_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hitPending <= 1'b0;
        end else if (w_enterSpawn) begin
            r_hitPending <= 1'b0;
        end else if (hit && (r_state != c_IDLE) && (r_state != c_GAME_OVER)) begin
            r_hitPending <= 1'b1;
        end
    end

    // Column is captured from the pre-advance LFSR value on SPAWN entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr   <= c_LFSR_SEED;
            r_enemyX <= 8'd0;
        end else begin
            r_lfsr <= w_lfsrNext;
            if (w_enterSpawn) begin
                r_enemyX <= w_spawnX;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kills <= 8'd0;
            r_speed <= c_SPEED_INIT;
            r_lives <= c_LIVES_INIT;
        end else if (w_restart) begin
            r_kills <= 8'd0;
            r_speed <= c_SPEED_INIT;
            r_lives <= c_LIVES_INIT;
        end else if (r_state == c_CHECK) begin
            if (w_hitNow) begin
                r_kills <= w_killsInc;
                if (w_levelUp && (r_speed < c_SPEED_MAX)) begin
                    r_speed <= r_speed + 3'd1;
                end
            end else if (bottomReached) begin
                r_lives <= w_livesDec;
            end
        end
    end

    assign inResetState          = (r_state == c_SPAWN);
    assign inUpdatePositionState = (r_state == c_UPDATE);
    assign drawReq               = (r_state == c_DRAW);
    assign gameOver              = (r_state == c_GAME_OVER);
    assign enemyXIn              = r_enemyX;
    assign speed                 = r_speed;
    assign lives                 = r_lives;
    assign kills                 = r_kills;

endmodule
`default_nettype wire
